// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder window: register offsets,
// status bit positions and the status byte packer.
package mmio_pkg;

    localparam logic [3:0] OFF_CNT0 = 4'h0;
    localparam logic [3:0] OFF_CNT1 = 4'h1;
    localparam logic [3:0] OFF_CNT2 = 4'h2;
    localparam logic [3:0] OFF_CNT3 = 4'h3;
    localparam logic [3:0] OFF_LED  = 4'h4;
    localparam logic [3:0] OFF_TX   = 4'h5;
    localparam logic [3:0] OFF_STAT = 4'h6;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;

    function automatic logic [7:0] status_byte(
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic [3:0] cnt
    );
        logic [7:0] s;
        s              = 8'h00;
        s[7:4]         = cnt;
        s[ST_EMPTY]    = empty;
        s[ST_FULL]     = full;
        s[ST_OVF]      = ovf;
        return s;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with explicit count; pushes while full are dropped
// and pops while empty are ignored. Head byte reads as 0 when empty.
module byte_fifo #(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_responder.sv
// 16-byte MMIO window: cycle counter with coherent shadow, LED register,
// TX byte FIFO with status/overflow. Read data is registered, 1-cycle latency.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int                    addr_width = 9,
    parameter logic [addr_width-1:0] BASE       = 9'h1F0,
    parameter int                    FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [addr_width-1:0] mem_raddr,
    input  logic [addr_width-1:0] mem_waddr,
    input  logic                  mem_write,
    input  logic [7:0]            mem_data_in,
    output logic [7:0]            mem_data_out,
    output logic                  mem_ready,
    output logic                  hit,
    output logic [7:0]            leds,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [7:0]    led_q, led_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    dout_q, dout_d;
    logic          hit_q, hit_d;
    logic          ready_q;

    logic          rd_hit, wr_hit;
    logic [3:0]    roff, woff;
    logic          push, pop;
    logic          f_empty, f_full;
    logic [CW-1:0] f_count;
    logic [7:0]    cnt8;
    logic [3:0]    cnt_nib;
    logic [7:0]    status;

    assign rd_hit = (mem_raddr[addr_width-1:4] == BASE[addr_width-1:4]);
    assign wr_hit = mem_write
                  & (mem_waddr[addr_width-1:4] == BASE[addr_width-1:4]);
    assign roff   = mem_raddr[3:0];
    assign woff   = mem_waddr[3:0];

    assign push     = wr_hit & (woff == OFF_TX);
    assign pop      = tx_valid & tx_ready;
    assign tx_valid = ~f_empty;

    // A 16-deep FIFO cannot show 16 in a nibble; report 15 and rely on full.
    assign cnt8    = 8'(f_count);
    assign cnt_nib = (cnt8 > 8'd15) ? 4'hF : cnt8[3:0];
    assign status  = status_byte(f_empty, f_full, ovf_q, cnt_nib);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (mem_data_in),
        .pop   (pop),
        .dout  (tx_data),
        .empty (f_empty),
        .full  (f_full),
        .count (f_count)
    );

    always_comb begin
        cnt_d    = cnt_q + 32'd1;
        shadow_d = shadow_q;
        led_d    = led_q;
        ovf_d    = ovf_q;
        dout_d   = 8'h00;
        hit_d    = rd_hit;

        if (rd_hit) begin
            case (roff)
                OFF_CNT0: begin
                    dout_d   = cnt_q[31:24];
                    shadow_d = cnt_q;
                end
                OFF_CNT1: dout_d = shadow_q[23:16];
                OFF_CNT2: dout_d = shadow_q[15:8];
                OFF_CNT3: dout_d = shadow_q[7:0];
                OFF_LED:  dout_d = led_q;
                OFF_STAT: dout_d = status;
                default:  dout_d = 8'h00;
            endcase
        end

        if (wr_hit && woff == OFF_CNT0) cnt_d = 32'd0;
        if (wr_hit && woff == OFF_LED)  led_d = mem_data_in;
        if (wr_hit && woff == OFF_STAT && mem_data_in[ST_OVF]) ovf_d = 1'b0;
        // Fullness is the pre-edge value, so a same-edge pop does not save it.
        if (push && f_full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= 32'd0;
            shadow_q <= 32'd0;
            led_q    <= 8'h00;
            ovf_q    <= 1'b0;
            dout_q   <= 8'h00;
            hit_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            led_q    <= led_d;
            ovf_q    <= ovf_d;
            dout_q   <= dout_d;
            hit_q    <= hit_d;
            ready_q  <= 1'b1;
        end
    end

    assign mem_data_out = dout_q;
    assign hit          = hit_q;
    assign mem_ready    = ready_q;
    assign leds         = led_q;

endmodule
